mlp_layer_engine: RTL and testbench

MLP_LAYER_ENGINE -- requirements
Module: mlp_layer_engine

---
 rtl/mlp_layer_engine_if.sv | 26 ++
 rtl/mlp_layer_engine.sv | 141 ++++++++++++++
 tb/tb_mlp_layer_engine.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_engine_if.sv
// mlp_layer_engine_if: start/beat handshake and result bundle for mlp_layer_engine
interface mlp_layer_engine_if #(
  parameter int DW = 8,
  parameter int LANES = 8
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  logic start;
  logic relu_en;
  logic [LANES*DW-1:0] bias;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_data;
  logic [LANES*DW-1:0] wt_data;
  logic busy;
  logic done;
  logic [LANES*DW-1:0] out_vec;
  logic [IW-1:0] max_idx;
  modport master (
    output start, relu_en, bias, in_valid, in_data, wt_data,
    input in_ready, busy, done, out_vec, max_idx
  );
  modport slave (
    input start, relu_en, bias, in_valid, in_data, wt_data,
    output in_ready, busy, done, out_vec, max_idx
  );
endinterface

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine: LANES-wide signed MAC layer with requantise, saturate, optional ReLU.
// Define MLP_ARGMAX_EN to add the sequential argmax stage driving max_idx.
module mlp_layer_engine #(
  parameter int DW = 8,
  parameter int LANES = 8,
  parameter int N_IN = 64,
  parameter int SHIFT = 4,
  parameter int ACCW = 2*DW+$clog2(N_IN)
) (
  input logic clk,
  input logic rst,
  mlp_layer_engine_if.slave io
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW = $clog2(N_IN > LANES ? N_IN : LANES) + 1;
  localparam int RW = ACCW + DW + SHIFT;
  localparam logic signed [RW-1:0] SMAX = RW'(2**(DW-1) - 1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] ACT = 3'd2;
  localparam logic [2:0] DONE = 3'd4;
`ifdef MLP_ARGMAX_EN
  localparam logic [2:0] ARGMAX = 3'd3;
  localparam logic [2:0] ACT_NEXT = ARGMAX;
`else
  localparam logic [2:0] ACT_NEXT = DONE;
`endif
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q [LANES];
  logic signed [ACCW-1:0] acc_d [LANES];
  logic [LANES*DW-1:0] bias_q, bias_d, out_q, out_d, res;
  logic relu_q, relu_d;
  logic [2*DW-1:0] p;
  logic signed [RW-1:0] sum, sh;
`ifdef MLP_ARGMAX_EN
  logic signed [DW-1:0] best_val_q, best_val_d, cur;
  logic [IW-1:0] best_idx_q, best_idx_d, max_idx_q, max_idx_d;
  logic take;
  assign io.max_idx = max_idx_q;
`else
  assign io.max_idx = '0;
`endif
  assign io.in_ready = state_q == ACCUM;
  assign io.busy = state_q != IDLE;
  assign io.done = state_q == DONE;
  assign io.out_vec = out_q;
  // Bias is aligned to the accumulator's fixed point before the floor shift.
  always_comb begin
    res = '0;
    sum = '0;
    sh = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = RW'(acc_q[i]) + (RW'($signed(bias_q[i*DW +: DW])) <<< SHIFT);
      sh = sum >>> SHIFT;
      res[i*DW +: DW] = (relu_q && sh[RW-1]) ? '0 :
                        sh > SMAX ? SMAX[DW-1:0] :
                        sh < SMIN ? SMIN[DW-1:0] : sh[DW-1:0];
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    bias_d = bias_q;
    relu_d = relu_q;
    out_d = out_q;
    p = '0;
`ifdef MLP_ARGMAX_EN
    cur = out_q[cnt_q[IW-1:0]*DW +: DW];
    take = cnt_q == '0 || cur > best_val_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    max_idx_d = max_idx_q;
`endif
    case (state_q)
      IDLE: if (io.start) begin
        state_d = ACCUM;
        cnt_d = '0;
        acc_d = '{default: '0};
        bias_d = io.bias;
        relu_d = io.relu_en;
      end
      ACCUM: if (io.in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          p = {{DW{io.in_data[DW-1]}}, io.in_data} *
              {{DW{io.wt_data[i*DW+DW-1]}}, io.wt_data[i*DW +: DW]};
          acc_d[i] = acc_q[i] + ACCW'($signed(p));
        end
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(N_IN - 1) ? ACT : ACCUM;
      end
      ACT: begin
        out_d = res;
        cnt_d = '0;
        state_d = ACT_NEXT;
      end
`ifdef MLP_ARGMAX_EN
      ARGMAX: begin
        best_val_d = take ? cur : best_val_q;
        best_idx_d = take ? cnt_q[IW-1:0] : best_idx_q;
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(LANES - 1) ? DONE : ARGMAX;
        max_idx_d = cnt_q == CW'(LANES - 1) ? best_idx_d : max_idx_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '{default: '0};
      bias_q <= '0;
      relu_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      bias_q <= bias_d;
      relu_q <= relu_d;
      out_q <= out_d;
    end
  end
`ifdef MLP_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      max_idx_q <= max_idx_d;
    end
  end
`endif
endmodule

// File: tb/tb_mlp_layer_engine.sv
// tb_mlp_layer_engine: directed and randomized runs checked against an arithmetic model of the layer
module tb_mlp_layer_engine;
  localparam int DW = 8;
  localparam int LANES = 8;
  localparam int N_IN = 64;
  localparam int SHIFT = 4;
`ifdef MLP_ARGMAX_EN
  localparam int EXP_LAT = LANES + 2;
`else
  localparam int EXP_LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;
  int din [N_IN];
  int wt [N_IN][LANES];
  int bias_v [LANES];
  bit relu;
  mlp_layer_engine_if #(.DW(DW), .LANES(LANES)) ui ();
  mlp_layer_engine #(.DW(DW), .LANES(LANES), .N_IN(N_IN), .SHIFT(SHIFT)) dut (
    .clk(clk),
    .rst(rst),
    .io(ui)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ui.done) done_cnt++;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int model_lane(int l);
    longint s = 0;
    longint d = longint'(1) << SHIFT;
    longint q;
    longint hi = (longint'(1) << (DW - 1)) - 1;
    for (int k = 0; k < N_IN; k++) s += longint'(din[k]) * wt[k][l];
    s += longint'(bias_v[l]) * d;
    q = s / d;
    if (s % d != 0 && s < 0) q--;
    if (q > hi) q = hi;
    if (q < -hi - 1) q = -hi - 1;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction
  function automatic int model_idx();
`ifdef MLP_ARGMAX_EN
    int b = 0;
    for (int l = 1; l < LANES; l++) if (model_lane(l) > model_lane(b)) b = l;
    return b;
`else
    return 0;
`endif
  endfunction
  task automatic fill(input int d, input int wscale, input int wconst, input int b);
    for (int k = 0; k < N_IN; k++) begin
      din[k] = d;
      for (int l = 0; l < LANES; l++) wt[k][l] = wscale * l + wconst;
    end
    for (int l = 0; l < LANES; l++) bias_v[l] = b;
  endtask
  task automatic rand_fill(input int r);
    for (int k = 0; k < N_IN; k++) begin
      din[k] = int'($urandom_range(2 * r)) - r;
      for (int l = 0; l < LANES; l++) wt[k][l] = int'($urandom_range(255)) - 128;
    end
    for (int l = 0; l < LANES; l++) bias_v[l] = int'($urandom_range(255)) - 128;
    relu = bit'($urandom_range(1));
  endtask
  task automatic run(input bit stall, input bit poke, input string tag);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    int lat = 1;
    int dn = done_cnt;
    bit acc;
    for (int l = 0; l < LANES; l++) ui.bias[l*DW +: DW] = DW'(bias_v[l]);
    ui.relu_en = relu;
    ui.start = 1'b1;
    @(posedge clk); #1;
    ui.start = 1'b0;
    while (k < N_IN && cyc < 4 * N_IN) begin
      ui.in_valid = stall ? (cyc % 2 == 1) : 1'b1;
      ui.start = poke && (cyc % 7 == 3);
      ui.in_data = DW'(din[k]);
      for (int l = 0; l < LANES; l++) ui.wt_data[l*DW +: DW] = DW'(wt[k][l]);
      acc = ui.in_valid && ui.in_ready;
      if (!ui.in_valid) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    ui.in_valid = 1'b0;
    ui.start = 1'b0;
    chk($sformatf("%s.beats", tag), cyc, N_IN + stalls);
    while (!ui.done && lat < 4 * LANES) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.lat", tag), lat, EXP_LAT);
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s.lane%0d", tag, l), $signed(ui.out_vec[l*DW +: DW]), model_lane(l));
    chk($sformatf("%s.max_idx", tag), ui.max_idx, model_idx());
    ui.start = poke;
    @(posedge clk); #1;
    ui.start = 1'b0;
    chk($sformatf("%s.done_pulse", tag), ui.done, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk($sformatf("%s.idle", tag), ui.busy, 0);
    chk($sformatf("%s.dones", tag), done_cnt - dn, 1);
  endtask
  initial begin
    ui.start = 1'b0;
    ui.relu_en = 1'b0;
    ui.bias = '0;
    ui.in_valid = 1'b0;
    ui.in_data = '0;
    ui.wt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", ui.busy, 0);
    chk("rst.done", ui.done, 0);
    chk("rst.in_ready", ui.in_ready, 0);
    chk("rst.out_vec", ui.out_vec, 0);
    chk("rst.max_idx", ui.max_idx, 0);
    rst = 1'b0;
    relu = 1'b0;
    fill(2, 1, 0, 0);
    run(1'b0, 1'b0, "base");
    fill(127, 0, 127, 0);
    run(1'b0, 1'b0, "sat");
    fill(16, 0, -1, 0);
    run(1'b0, 1'b0, "neg");
    relu = 1'b1;
    run(1'b0, 1'b0, "relu");
    relu = 1'b0;
    fill(2, 1, 0, 0);
    run(1'b1, 1'b0, "stall");
    d0 = done_cnt;
    ui.bias = '0;
    ui.relu_en = 1'b0;
    ui.start = 1'b1;
    @(posedge clk); #1;
    ui.start = 1'b0;
    ui.in_valid = 1'b1;
    ui.in_data = DW'(2);
    for (int l = 0; l < LANES; l++) ui.wt_data[l*DW +: DW] = DW'(l);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    ui.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", ui.busy, 0);
    chk("abort.in_ready", ui.in_ready, 0);
    chk("abort.out_vec", ui.out_vec, 0);
    chk("abort.max_idx", ui.max_idx, 0);
    repeat (20) begin @(posedge clk); #1; end
    chk("abort.dones", done_cnt - d0, 0);
    run(1'b0, 1'b0, "rerun");
    run(1'b0, 1'b1, "poke");
    for (int t = 0; t < 8; t++) begin
      rand_fill(t % 2 == 1 ? 127 : 3);
      run(bit'($urandom_range(1)), bit'($urandom_range(1)), $sformatf("rand%0d", t));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
